ps2_keyboard_rx_fifo: RTL
=========================

Name: ps2_keyboard_rx_fifo

Overview:
Parametrised next-generation PS/2 keyboard receiver.
- Deserialises 11-bit device frames into scan codes.
- Folds E0 (extended) and F0 (break) prefixes into per-entry flags.
- Buffers decoded keys in a show-ahead FIFO instead of a single keycode register.
- Reports sticky parity, framing, timeout and overrun errors to the host-side interrupt logic.

Parameters:
FIFO_DEPTH, 8, number of decoded key entries; power of two, minimum 2
SYNC_STAGES, 2, synchroniser flops on device_clock and device_data; minimum 2
FILTER_CYCLES, 2, consecutive equal samples required before the filtered device_clock changes level
TIMEOUT_CYCLES, 2000, maximum system clocks between falling edges inside a frame before abort

Ports:
clock  in  1  system clock
reset  in  1  reset
device_clock  in  1  PS/2 clock line, asynchronous
device_data  in  1  PS/2 data line, asynchronous
irq  out  1  FIFO non-empty
keycode  out  8  scan code at FIFO head
break_flag  out  1  head entry was preceded by F0
extended_flag  out  1  head entry was preceded by E0
pop  in  1  consume head entry (replaces clear_keycode)
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
parity_error  out  1  sticky
frame_error  out  1  sticky; bad start/stop bit or timeout
overrun  out  1  sticky; push attempted while full
error_clear  in  1  clears the three sticky flags

Behaviour:
- Reset is asynchronous, active-high. Reset values:
  - irq, keycode, break_flag, extended_flag, fifo_count: 0
  - error flags: 0
  - FSM: IDLE; pending prefixes cleared; FIFO pointers 0
- Reset mid-frame discards the partial frame.
- Input conditioning:
  - Both lines pass through SYNC_STAGES flops.
  - Filtered clock changes only after FILTER_CYCLES identical synchronised samples.
  - A sample event is a 1-to-0 transition of the filtered clock; data is sampled on the synchronised data in that same cycle.
- Frame format: start(0), data[0..7] LSB first, odd parity, stop(1).
- FSM states:
  - IDLE -> START_CHECK on a sample event. If data=1 there: set frame_error, return to IDLE.
  - DATA: 8 events, shift right.
  - PARITY: 1 event; check ^{data,parity}==1.
  - STOP: 1 event; data must be 1, else set frame_error and discard.
- Timeout:
  - A counter is reset on every sample event and runs in any non-IDLE state.
  - Reaching TIMEOUT_CYCLES -> frame_error set, FSM to IDLE, byte discarded.
- Byte decode, on a valid stop:
  - Parity bad: set parity_error, drop byte, clear both pending prefixes.
  - Byte 8'hE0: set pending_ext, no push.
  - Byte 8'hF0: set pending_brk, no push.
  - Other bytes: push {pending_ext, pending_brk, byte}, then clear both pending prefixes.
- Latency:
  - Stop bit sampled in cycle N; FIFO written at the clock edge ending N+1.
  - irq/keycode valid after that edge.
- FIFO:
  - Show-ahead: keycode/flags always reflect the head entry.
  - When empty, keycode/flags read as 0.
  - pop while empty: ignored.
  - Push while full without pop: entry dropped, overrun set, prefixes still cleared.
  - Push and pop in the same cycle while full: both succeed, count unchanged, no overrun.
  - Push and pop in the same cycle while empty: push succeeds, pop ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count ranges 0..FIFO_DEPTH.
- Sticky flags: error_clear clears them. If a new error and error_clear occur in the same cycle, set wins.
- irq = (fifo_count != 0), registered.

Decomposition:
- Package ps2_rx_pkg holds:
  - FSM state enum: IDLE, START_CHECK, DATA, PARITY, STOP.
  - Constants PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BRK=8'hF0.
  - Packed struct key_entry_t {extended, brk, code[7:0]}.
- One sub-module, ps2_rx_fifo: synchronous show-ahead FIFO of key_entry_t, parametrised by depth, with full/empty/count outputs.
- Synchroniser, filter, FSM and prefix logic stay in the top module.

Test Plan:
- Frame start=0, data 0x55 LSB first, parity 1, stop 1, 3-cycle half periods -> irq=1, keycode=0x55, break_flag=0, extended_flag=0, fifo_count=1; pop -> irq=0, count=0.
- Frames 0xF0 then 0x1C, pop -> keycode=0x1C, break_flag=1, extended_flag=0.
- Frames 0xE0, 0xF0, 0x75 -> one entry: keycode=0x75, break_flag=1, extended_flag=1.
- Frame 0xAA with parity 0 -> nothing pushed, parity_error=1.
  - A following valid 0x1C has both flags 0.
  - error_clear -> parity_error=0.
- Nine frames 0x01..0x09 with FIFO_DEPTH=8, no pop -> count=8, overrun=1, head=0x01.
  - Simultaneous pop and push when full -> count stays 8, no new overrun.
- Start bit plus 3 data bits, then the line idles 2500 cycles -> frame_error=1, FSM IDLE.
  - Next valid 0x29 frame is received correctly.
  - Assert reset mid-frame -> all outputs 0.

Source files
------------

// File: rtl/ps2_rx_pkg.sv
// Shared types for the PS/2 keyboard receiver.
// FSM states, prefix bytes and the decoded key entry.
package ps2_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_CHECK,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef struct packed {
    logic       extended;
    logic       brk;
    logic [7:0] code;
  } key_entry_t;

endpackage

// File: rtl/ps2_rx_fifo.sv
// Show-ahead FIFO of decoded key entries.
// Head reads as zero while empty; a pop on a full FIFO frees room for a push.
module ps2_rx_fifo
  import ps2_rx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_i,
  input  key_entry_t             wdata_i,
  input  logic                   pop_i,
  output key_entry_t             head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  key_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_pop;
  logic          do_push;

  assign empty_o = (cnt_q == '0);
  assign full_o  = cnt_q[AW];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  assign head_o  = empty_o ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/ps2_keyboard_rx_fifo.sv
// PS/2 keyboard receiver: sync, glitch filter, frame FSM,
// E0/F0 prefix folding and a key FIFO with sticky error flags.
module ps2_keyboard_rx_fifo
  import ps2_rx_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        device_clock,
  input  logic                        device_data,
  output logic                        irq,
  output logic [7:0]                  keycode,
  output logic                        break_flag,
  output logic                        extended_flag,
  input  logic                        pop,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        parity_error,
  output logic                        frame_error,
  output logic                        overrun,
  input  logic                        error_clear
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   clk_s;
  logic                   dat_s;
  logic                   filt_q;
  logic [FW-1:0]          fcnt_q;
  logic                   sample;

  ps2_state_e    state_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          start_q;
  logic          par_ok_q;
  logic [TW-1:0] tmo_q;
  logic          byte_vld_q;
  logic          ferr_q;

  logic          pend_ext_q;
  logic          pend_brk_q;
  logic          perr_q;
  logic          frerr_q;
  logic          ovr_q;

  logic          good;
  logic          is_ext;
  logic          is_brk;
  logic          push;
  logic          full;
  logic          empty;
  key_entry_t    entry;
  key_entry_t    head;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  // Lines idle high, so the synchronisers reset high to avoid a fake edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], device_clock};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], device_data};
    end
  end

  assign sample = filt_q & ~clk_s
                & (fcnt_q == FW'(FILTER_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else if (clk_s == filt_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FW'(FILTER_CYCLES - 1)) begin
      filt_q <= clk_s;
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + FW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_q      <= '0;
      shift_q    <= '0;
      start_q    <= 1'b0;
      par_ok_q   <= 1'b0;
      tmo_q      <= '0;
      byte_vld_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      byte_vld_q <= 1'b0;
      ferr_q     <= 1'b0;
      if (state_q == IDLE || sample) tmo_q <= '0;
      else                           tmo_q <= tmo_q + TW'(1);
      if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYCLES)) begin
        ferr_q  <= 1'b1;
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: if (sample) begin
            start_q <= dat_s;
            state_q <= START_CHECK;
          end
          START_CHECK: begin
            bit_q   <= '0;
            ferr_q  <= start_q;
            state_q <= start_q ? IDLE : DATA;
          end
          DATA: if (sample) begin
            shift_q <= {dat_s, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= PARITY;
          end
          PARITY: if (sample) begin
            par_ok_q <= ^{shift_q, dat_s};
            state_q  <= STOP;
          end
          STOP: if (sample) begin
            byte_vld_q <= dat_s;
            ferr_q     <= ~dat_s;
            state_q    <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign good   = byte_vld_q & par_ok_q;
  assign is_ext = good & (shift_q == PS2_PREFIX_EXT);
  assign is_brk = good & (shift_q == PS2_PREFIX_BRK);
  assign push   = good & ~is_ext & ~is_brk;
  assign entry  = '{extended: pend_ext_q, brk: pend_brk_q, code: shift_q};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_ext_q <= 1'b0;
      pend_brk_q <= 1'b0;
      perr_q     <= 1'b0;
      frerr_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      if (push || (byte_vld_q && !par_ok_q)) begin
        pend_ext_q <= 1'b0;
        pend_brk_q <= 1'b0;
      end else begin
        if (is_ext) pend_ext_q <= 1'b1;
        if (is_brk) pend_brk_q <= 1'b1;
      end
      perr_q  <= (perr_q & ~error_clear) | (byte_vld_q & ~par_ok_q);
      frerr_q <= (frerr_q & ~error_clear) | ferr_q;
      ovr_q   <= (ovr_q & ~error_clear) | (push & full & ~pop);
    end
  end

  ps2_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .push_i (push),
    .wdata_i(entry),
    .pop_i  (pop),
    .head_o (head),
    .full_o (full),
    .empty_o(empty),
    .count_o(fifo_count)
  );

  assign irq           = ~empty;
  assign keycode       = head.code;
  assign break_flag    = head.brk;
  assign extended_flag = head.extended;
  assign parity_error  = perr_q;
  assign frame_error   = frerr_q;
  assign overrun       = ovr_q;

endmodule
